// File: rtl/fpga_clock_enables.sv
// fpga_clock_enables
//   Generates NCHAN one-cycle clock-enable strobes from the single buffered DCM
//   clock. Strobes are held off until the DCM lock has been stable for
//   LOCK_CYCLES cycles. Panel switches are synchronised and debounced. The
//   debounced switches pick channel 0's rate or put it in single-step mode.
//
// Ports
//   clk          system clock (DCM output, buffered)
//   reset_n      asynchronous active-low reset
//   dcm_locked   DCM LOCKED status (synchronised internally)
//   slideswitch  raw panel switches; MSB selects single-step mode for channel 0
//   step_req     raw single-step button, active high
//   wr_en        divide-register write strobe
//   wr_chan      channel being written (out-of-range values are ignored)
//   wr_data      divide value D; the strobe period is D+1 cycles
//   run          lock qualified; enables may fire
//   ce           registered one-cycle enable strobes, one per channel
//   switches     synchronised, debounced switch vector
module fpga_clock_enables #(
  parameter int NCHAN = 2,
  parameter int CNT_W = 24,
  parameter int SW_W = 8,
  parameter int DEB_W = 16,
  parameter int LOCK_CYCLES = 16,
  parameter logic [CNT_W-1:0] DIV_INIT = '0,
  localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dcm_locked,
  input  logic [SW_W-1:0]  slideswitch,
  input  logic             step_req,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_chan,
  input  logic [CNT_W-1:0] wr_data,
  output logic             run,
  output logic [NCHAN-1:0] ce,
  output logic [SW_W-1:0]  switches
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [0:0] {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

  // Channel 0 switch-selected divide: 2^min(2k+1,CNT_W)-1, where k is the
  // highest set rate bit. The per-bit compare saturates at all-ones naturally.
  function automatic logic [CNT_W-1:0] rate_div(input logic [SW_W-2:0] sel);
    logic [CNT_W-1:0] res;
    int msb;
    msb = 0;
    for (int b = 0; b < SW_W - 1; b++) begin
      msb = sel[b] ? b : msb;
    end
    for (int b = 0; b < CNT_W; b++) begin
      res[b] = (b < (2 * msb + 1));
    end
    return res;
  endfunction

  state_t                        state_q, state_d;
  logic [LCK_W-1:0]              lock_cnt_q, lock_cnt_d;
  logic                          run_q, run_d;
  logic                          lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
  logic                          step_s1_q, step_s1_d, step_s2_q, step_s2_d;
  logic                          step_prev_q, step_prev_d;
  logic [SW_W-1:0]               sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [SW_W-1:0]               sw_prev_q, sw_prev_d;
  logic [SW_W-1:0]               switches_q, switches_d;
  logic [DEB_W-1:0]              deb_cnt_q, deb_cnt_d;
  logic [NCHAN-1:0]              ce_q, ce_d;
  logic [NCHAN-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCHAN-1:0][CNT_W-1:0]   pend_q, pend_d;
  logic [NCHAN-1:0][CNT_W-1:0]   act_q, act_d;
  logic [NCHAN-1:0][CNT_W-1:0]   tgt;

  logic running;
  logic step_rise;
  logic step_mode;
  logic rate_any;

  assign running   = (state_q == RUN) && lock_s2_q;
  assign step_rise = step_s2_q & ~step_prev_q;
  assign step_mode = switches_q[SW_W-1];
  assign rate_any  = |switches_q[SW_W-2:0];

  // Two-flop synchronisers plus the edge-detect and compare history stages.
  always_comb begin
    lock_s1_d   = dcm_locked;
    lock_s2_d   = lock_s1_q;
    step_s1_d   = step_req;
    step_s2_d   = step_s1_q;
    step_prev_d = step_s2_q;
    sw_s1_d     = slideswitch;
    sw_s2_d     = sw_s1_q;
    sw_prev_d   = sw_s2_q;
  end

  // Lock qualification FSM: LOCK_CYCLES consecutive synced highs enter RUN.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    run_d      = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s2_q) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = RUN;
            lock_cnt_d = '0;
          end else begin
            state_d    = WAIT_LOCK;
            lock_cnt_d = lock_cnt_q + LCK_W'(1);
          end
        end else begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end
      end
      RUN: begin
        lock_cnt_d = '0;
        if (lock_s2_q) begin
          state_d = RUN;
          run_d   = 1'b1;
        end else begin
          state_d = WAIT_LOCK;
          run_d   = 1'b0;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
        run_d      = 1'b0;
      end
    endcase
  end

  // Switch debounce: any change restarts the stability count.
  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    switches_d = switches_q;
    if (sw_s2_q != sw_prev_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == {DEB_W{1'b1}}) begin
      switches_d = sw_s2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // Channel dividers. A new divide (register or switch rate) is only loaded at a
  // wrap so no period is shortened or stretched; outside RUN it loads at once.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    ce_d   = '0;
    tgt    = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      // An out-of-range wr_chan matches no channel and is dropped.
      if (wr_en && (int'(wr_chan) == ch)) begin
        pend_d[ch] = wr_data;
      end else begin
        pend_d[ch] = pend_q[ch];
      end
      // Using pend_d lets a write that coincides with a wrap take effect there.
      if ((ch == 0) && rate_any) begin
        tgt[ch] = rate_div(switches_q[SW_W-2:0]);
      end else begin
        tgt[ch] = pend_d[ch];
      end
      if (!running) begin
        cnt_d[ch] = '0;
        ce_d[ch]  = 1'b0;
        act_d[ch] = tgt[ch];
      end else if ((ch == 0) && step_mode) begin
        cnt_d[ch] = '0;
        ce_d[ch]  = step_rise;
        act_d[ch] = tgt[ch];
      end else if (cnt_q[ch] == act_q[ch]) begin
        cnt_d[ch] = '0;
        ce_d[ch]  = 1'b1;
        act_d[ch] = tgt[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        ce_d[ch]  = 1'b0;
        act_d[ch] = act_q[ch];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= '0;
      run_q       <= 1'b0;
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sw_prev_q   <= '0;
      switches_q  <= '0;
      deb_cnt_q   <= '0;
      ce_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= {NCHAN{DIV_INIT}};
      act_q       <= {NCHAN{DIV_INIT}};
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      run_q       <= run_d;
      lock_s1_q   <= lock_s1_d;
      lock_s2_q   <= lock_s2_d;
      step_s1_q   <= step_s1_d;
      step_s2_q   <= step_s2_d;
      step_prev_q <= step_prev_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      sw_prev_q   <= sw_prev_d;
      switches_q  <= switches_d;
      deb_cnt_q   <= deb_cnt_d;
      ce_q        <= ce_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

  assign run      = run_q;
  assign ce       = ce_q;
  assign switches = switches_q;

endmodule

// File: tb/tb_fpga_clock_enables.sv
// Self-checking bench for fpga_clock_enables. Expected strobe times come from
// the behavioural rules: period D+1, first strobe D cycles after run rises,
// new divides take effect at the first wrap at/after the write, switch and
// lock inputs see fixed synchroniser/debounce latencies.
module tb_fpga_clock_enables;

  localparam int NCHAN = 3;
  localparam int CNT_W = 4;
  localparam int SW_W = 4;
  localparam int DEB_W = 3;
  localparam int LOCK_CYCLES = 6;
  localparam int DINIT = 2;
  localparam int DEB_LAT = (1 << DEB_W) + 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             dcm_locked;
  logic [SW_W-1:0]  slideswitch;
  logic             step_req;
  logic             wr_en;
  logic [1:0]       wr_chan;
  logic [CNT_W-1:0] wr_data;
  logic             run;
  logic [NCHAN-1:0] ce;
  logic [SW_W-1:0]  switches;

  fpga_clock_enables #(
    .NCHAN(NCHAN), .CNT_W(CNT_W), .SW_W(SW_W), .DEB_W(DEB_W),
    .LOCK_CYCLES(LOCK_CYCLES), .DIV_INIT(4'd2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dcm_locked(dcm_locked),
    .slideswitch(slideswitch), .step_req(step_req), .wr_en(wr_en),
    .wr_chan(wr_chan), .wr_data(wr_data), .run(run), .ce(ce),
    .switches(switches)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bounce_bad = 0;
  int strobes[NCHAN][$];
  int cur_div[NCHAN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; sample #1 later and log strobe edge numbers.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int ch = 0; ch < NCHAN; ch++) begin
        if (ce[ch] === 1'b1) strobes[ch].push_back(cyc);
      end
    end
  endtask

  task automatic clear_q();
    for (int ch = 0; ch < NCHAN; ch++) strobes[ch].delete();
  endtask

  task automatic hold_ticks(input int n, input logic [SW_W-1:0] exp_sw);
    repeat (n) begin
      tick(1);
      if (switches !== exp_sw) bounce_bad++;
    end
  endtask

  task automatic wait_run(input string tag, output int edge_at);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    edge_at = -1;
    while (!seen && n < 60) begin
      tick(1);
      n++;
      if (run === 1'b1) begin
        seen = 1;
        edge_at = cyc;
      end
    end
    chk(tag, seen ? n : -1, LOCK_CYCLES + 3);
  endtask

  task automatic write_div(input int ch, input int d);
    wr_en = 1'b1;
    wr_chan = 2'(ch);
    wr_data = CNT_W'(d);
    tick(1);
    wr_en = 1'b0;
    if (ch < NCHAN) cur_div[ch] = d;
  endtask

  task automatic check_train(input string tag, input int ch, input int first, input int period, input int n);
    int sz;
    sz = strobes[ch].size();
    for (int i = 0; i < n; i++) begin
      chk(tag, (i < sz) ? strobes[ch][i] : -1, first + i * period);
    end
  endtask

  task automatic check_gaps(input string tag, input int ch, input int period, input int min_n);
    int sz;
    sz = strobes[ch].size();
    chk({tag, "_cnt"}, (sz >= min_n) ? 1 : 0, 1);
    for (int i = 1; i < sz; i++) begin
      chk({tag, "_gap"}, strobes[ch][i] - strobes[ch][i-1], period);
    end
  endtask

  // Old period up to the first wrap at/after edge w, new period afterwards.
  task automatic analyze(input string tag, input int ch, input int w, input int oldd, input int newd);
    int j;
    int sz;
    j = -1;
    sz = strobes[ch].size();
    for (int i = 0; i < sz; i++) begin
      if (j < 0 && strobes[ch][i] >= w) j = i;
    end
    chk({tag, "_seen"}, (j >= 1 && j + 2 < sz) ? 1 : 0, 1);
    if (j >= 1 && j + 2 < sz) begin
      for (int i = 1; i <= j; i++) begin
        chk({tag, "_old"}, strobes[ch][i] - strobes[ch][i-1], oldd + 1);
      end
      chk({tag, "_new1"}, strobes[ch][j+1] - strobes[ch][j], newd + 1);
      chk({tag, "_new2"}, strobes[ch][j+2] - strobes[ch][j+1], newd + 1);
      chk({tag, "_lat"}, (strobes[ch][j+1] - w <= oldd + newd + 2) ? 1 : 0, 1);
    end
  endtask

  task automatic do_write(input string tag, input int ch, input int newd, input int ph);
    int oldd;
    int w;
    oldd = cur_div[ch];
    clear_q();
    tick(oldd + 1 + ph);
    write_div(ch, newd);
    w = cyc;
    tick(oldd + 2 * newd + 8);
    analyze(tag, ch, w, oldd, newd);
  endtask

  initial begin
    int r_edge;
    int s_edge;
    int p1;
    int p2;
    int last;
    int total;

    for (int ch = 0; ch < NCHAN; ch++) cur_div[ch] = DINIT;
    reset_n = 1'b0;
    dcm_locked = 1'b1;
    slideswitch = '0;
    step_req = 1'b0;
    wr_en = 1'b0;
    wr_chan = '0;
    wr_data = '0;

    // Reset state
    #12;
    chk("rst_run", run, 0);
    chk("rst_ce", ce, 0);
    chk("rst_sw", switches, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Lock qualification with a one-cycle glitch
    tick(4);
    chk("pre_glitch_run", run, 0);
    dcm_locked = 1'b0;
    tick(1);
    dcm_locked = 1'b1;
    clear_q();
    wait_run("lock_run_rise", r_edge);
    tick(20);
    for (int ch = 0; ch < NCHAN; ch++) check_train("div_init", ch, r_edge + DINIT, DINIT + 1, 5);

    // Divide writes: no runt, coincident-wrap rule, D=0, random values
    do_write("d1_3", 1, 3, 0);
    do_write("d1_9", 1, 9, 2);
    do_write("d2_0", 2, 0, 1);
    repeat (6) begin
      int ch;
      ch = int'($urandom_range(1, 2));
      do_write("rnd_wr", ch, int'($urandom_range(0, 15)), int'($urandom_range(0, cur_div[ch])));
    end

    // Out-of-range channel write is ignored
    write_div(3, 1);
    clear_q();
    tick(40);
    for (int ch = 0; ch < NCHAN; ch++) check_gaps("bad_chan", ch, cur_div[ch] + 1, 2);

    // Switch debounce and channel 0 rate (k=1 -> period 8)
    clear_q();
    slideswitch = 4'b0010;
    tick(DEB_LAT - 1);
    chk("deb_hold", switches, 0);
    tick(1);
    chk("deb_update", switches, 2);
    s_edge = cyc;
    tick(30);
    analyze("sw_rate", 0, s_edge + 1, DINIT, 7);

    // Bounce: three toggles, switches hold until the final value is stable
    bounce_bad = 0;
    slideswitch = 4'b0000;
    hold_ticks(2, 4'b0010);
    slideswitch = 4'b0010;
    hold_ticks(2, 4'b0010);
    slideswitch = 4'b0000;
    last = cyc + 1;
    hold_ticks(last + DEB_LAT - 2 - cyc, 4'b0010);
    chk("bounce_hold", bounce_bad, 0);
    tick(1);
    chk("bounce_settle", switches, 0);

    // Saturated rate: k=2 -> 2^min(5,4)-1 = 15
    slideswitch = 4'b0100;
    tick(DEB_LAT);
    chk("sat_sw", switches, 4);
    clear_q();
    tick(55);
    check_gaps("sat_rate", 0, 16, 3);

    // Single-step mode
    slideswitch = 4'b1000;
    tick(DEB_LAT);
    chk("step_sw", switches, 8);
    clear_q();
    tick(3);
    step_req = 1'b1;
    p1 = cyc + 1;
    tick(3);
    step_req = 1'b0;
    tick(5);
    step_req = 1'b1;
    p2 = cyc + 1;
    tick(3);
    step_req = 1'b0;
    tick(20);
    chk("step_count", strobes[0].size(), 2);
    check_train("step_time", 0, p1 + 2, p2 - p1, 2);
    check_gaps("step_ch1", 1, cur_div[1] + 1, 2);

    // Leave step mode: counter restarts from 0
    slideswitch = 4'b0000;
    tick(DEB_LAT);
    s_edge = cyc;
    clear_q();
    tick(15);
    check_train("step_exit", 0, s_edge + DINIT + 1, DINIT + 1, 4);

    // Lock loss in RUN, write while unlocked, relock
    dcm_locked = 1'b0;
    tick(3);
    chk("unlock_run", run, 0);
    chk("unlock_ce", ce, 0);
    clear_q();
    write_div(2, 5);
    tick(5);
    total = 0;
    for (int ch = 0; ch < NCHAN; ch++) total += strobes[ch].size();
    chk("unlock_quiet", total, 0);
    dcm_locked = 1'b1;
    clear_q();
    wait_run("relock_run_rise", r_edge);
    tick(30);
    for (int ch = 0; ch < NCHAN; ch++) check_train("relock", ch, r_edge + cur_div[ch], cur_div[ch] + 1, 2);

    // Asynchronous reset mid-period
    slideswitch = 4'b0001;
    tick(DEB_LAT);
    chk("pre_rst_sw", switches, 1);
    chk("pre_rst_run", run, 1);
    slideswitch = 4'b0000;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_run", run, 0);
    chk("async_rst_ce", ce, 0);
    chk("async_rst_sw", switches, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int ch = 0; ch < NCHAN; ch++) cur_div[ch] = DINIT;
    clear_q();
    wait_run("post_rst_run_rise", r_edge);
    tick(20);
    for (int ch = 0; ch < NCHAN; ch++) check_train("post_rst_div", ch, r_edge + DINIT, DINIT + 1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
